// File: rtl/syst_pkg.sv
// Shared defaults and the column partial-sum type for the systolic drain path.
package syst_pkg;
  localparam int SYST_N_COLS   = 4;
  localparam int SYST_SO_WIDTH = 17;
  localparam int SYST_DEPTH    = 4;

  typedef logic [SYST_SO_WIDTH-1:0] psum_t;
endpackage

// File: rtl/syst_row_fifo.sv
// Row buffer for aligned result rows.
// A push into a full buffer is only accepted when a pop frees a slot on the same edge.
module syst_row_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Storage is not reset, so an empty buffer presents zeros.
  assign data_o  = empty ? '0 : mem[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/syst_deskew.sv
// Realigns the diagonally skewed bottom-row outputs of a systolic array into whole rows
// and buffers them for a valid/ready consumer.
module syst_deskew
  import syst_pkg::*;
#(
  parameter int N_COLS   = SYST_N_COLS,
  parameter int SO_WIDTH = SYST_SO_WIDTH,
  parameter int DEPTH    = SYST_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_COLS-1:0]            valid_i,
  input  logic [N_COLS*SO_WIDTH-1:0]   psumm_i,
  output logic [N_COLS*SO_WIDTH-1:0]   row_o,
  output logic                         row_valid_o,
  input  logic                         row_ready_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         ovf_o,
  output logic                         align_err_o,
  input  logic                         err_clr_i
);
  localparam int RW = N_COLS * SO_WIDTH;

  logic [N_COLS-1:0] al_v;
  logic [RW-1:0]     al_d;
  logic              all_v;
  logic              skew_err;
  logic              drop;
  logic              ovf_q;
  logic              align_err_q;

  // Column c lags column 0 by c cycles, so it is delayed by N_COLS-1-c stages to line up
  // with the live last column. Stages shift every cycle whether or not data is valid.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    localparam int L = N_COLS - 1 - c;
    if (L == 0) begin : g_live
      assign al_v[c]                       = valid_i[c];
      assign al_d[c*SO_WIDTH +: SO_WIDTH]  = psumm_i[c*SO_WIDTH +: SO_WIDTH];
    end else begin : g_dly
      logic [L-1:0]        v_q;
      logic [SO_WIDTH-1:0] d_q [L];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= '0;
          for (int k = 0; k < L; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= valid_i[c];
          d_q[0] <= psumm_i[c*SO_WIDTH +: SO_WIDTH];
          for (int k = 1; k < L; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign al_v[c]                      = v_q[L-1];
      assign al_d[c*SO_WIDTH +: SO_WIDTH] = d_q[L-1];
    end
  end

  // A partially valid aligned vector means the producer broke the skew contract.
  assign all_v    = &al_v;
  assign skew_err = (|al_v) && !all_v;

  // Handshake: row_o is offered while row_valid_o is high and must hold steady until
  // row_ready_i is seen high on a rising edge, which pops it; ready has no effect when empty.
  syst_row_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (all_v),
    .data_i  (al_d),
    .pop_i   (row_ready_i),
    .data_o  (row_o),
    .count_o (count_o),
    .drop_o  (drop)
  );

  assign row_valid_o = (count_o != '0);

  // A new error event on the clear cycle keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      ovf_q       <= drop     || (ovf_q       && !err_clr_i);
      align_err_q <= skew_err || (align_err_q && !err_clr_i);
    end
  end

  assign ovf_o       = ovf_q;
  assign align_err_o = align_err_q;
endmodule

// File: tb/tb_syst_deskew.sv
// Directed bench for syst_deskew: rows are presented unskewed and fanned out diagonally
// by a small producer model, then checked against hand-computed expectations.
module tb_syst_deskew;
  import syst_pkg::*;

  localparam int NC = 4;
  localparam int SW = 17;
  localparam int DP = 4;
  localparam int RW = NC * SW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NC-1:0] valid_i;
  logic [RW-1:0] psumm_i;
  logic [RW-1:0] row_o;
  logic          row_valid_o;
  logic          row_ready_i;
  logic [2:0]    count_o;
  logic          ovf_o;
  logic          align_err_o;
  logic          err_clr_i;

  int n_vec = 0;
  int n_err = 0;

  // Producer history: entry k is the row presented k ticks ago.
  logic [NC-1:0] h_m [NC];
  logic [RW-1:0] h_d [NC];

  always #5 clk_i = ~clk_i;

  syst_deskew #(
    .N_COLS   (NC),
    .SO_WIDTH (SW),
    .DEPTH    (DP)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .psumm_i     (psumm_i),
    .row_o       (row_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .align_err_o (align_err_o),
    .err_clr_i   (err_clr_i)
  );

  function automatic logic [RW-1:0] mk(input int a, input int b, input int c, input int d);
    psum_t pa, pb, pc, pd;
    pa = psum_t'(a);
    pb = psum_t'(b);
    pc = psum_t'(c);
    pd = psum_t'(d);
    return {pd, pc, pb, pa};
  endfunction

  function automatic logic [RW-1:0] row(input int k);
    return mk(k, k + 100, k + 200, k + 300);
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < NC; k++) begin
      h_m[k] = '0;
      h_d[k] = '0;
    end
    valid_i = '0;
    psumm_i = '0;
  endtask

  // Present one unskewed row (mask m), drive the skewed column inputs, advance one edge.
  task automatic tick(input logic [NC-1:0] m, input logic [RW-1:0] r,
                      input logic rdy, input logic clr);
    for (int k = NC - 1; k > 0; k--) begin
      h_m[k] = h_m[k-1];
      h_d[k] = h_d[k-1];
    end
    h_m[0] = m;
    h_d[0] = r;
    for (int c = 0; c < NC; c++) begin
      valid_i[c]           = h_m[c][c];
      psumm_i[c*SW +: SW]  = h_d[c][c*SW +: SW];
    end
    row_ready_i = rdy;
    err_clr_i   = clr;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    row_ready_i = 1'b0;
    err_clr_i   = 1'b0;
    clear_hist();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", count_o, 0);
    check("rst_valid", row_valid_o, 0);
    check("rst_row", row_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_align", align_err_o, 0);
    rst_ni = 1'b1;

    // Single row, consumer ready
    tick(4'hF, mk(1, 2, 3, 4), 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s1_not_yet", row_valid_o, 0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s1_valid", row_valid_o, 1);
    check("s1_count", count_o, 1);
    check("s1_row", row_o, mk(1, 2, 3, 4));
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s1_drained_count", count_o, 0);
    check("s1_drained_valid", row_valid_o, 0);

    // Five rows into a stalled consumer: fifth is dropped
    for (int k = 10; k <= 14; k++) tick(4'hF, row(k), 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    check("s2_full_count", count_o, 4);
    check("s2_no_ovf_yet", ovf_o, 0);
    tick(4'h0, '0, 1'b0, 1'b0);
    check("s2_count", count_o, 4);
    check("s2_ovf", ovf_o, 1);
    check("s2_head_stable", row_o, row(10));
    for (int k = 10; k <= 13; k++) begin
      check($sformatf("s2_drain_%0d", k), row_o, row(k));
      tick(4'h0, '0, 1'b1, 1'b0);
    end
    check("s2_empty_count", count_o, 0);
    check("s2_empty_valid", row_valid_o, 0);
    check("s2_ovf_sticky", ovf_o, 1);
    tick(4'h0, '0, 1'b0, 1'b1);
    check("s2_ovf_clr", ovf_o, 0);

    // Full buffer, write coincides with pop
    for (int k = 20; k <= 23; k++) tick(4'hF, row(k), 1'b0, 1'b0);
    repeat (3) tick(4'h0, '0, 1'b0, 1'b0);
    check("s3_full", count_o, 4);
    tick(4'hF, row(24), 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s3_count_held", count_o, 4);
    check("s3_no_ovf", ovf_o, 0);
    for (int k = 21; k <= 24; k++) begin
      check($sformatf("s3_drain_%0d", k), row_o, row(k));
      tick(4'h0, '0, 1'b1, 1'b0);
    end
    check("s3_empty", count_o, 0);

    // One row buffered, write coincides with pop
    tick(4'hF, row(30), 1'b0, 1'b0);
    repeat (3) tick(4'h0, '0, 1'b0, 1'b0);
    check("s3b_one", count_o, 1);
    tick(4'hF, row(31), 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s3b_count", count_o, 1);
    check("s3b_valid", row_valid_o, 1);
    check("s3b_row", row_o, row(31));
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s3b_empty", count_o, 0);

    // Column 2 missing
    tick(4'b1011, row(40), 1'b1, 1'b0);
    repeat (3) tick(4'h0, '0, 1'b1, 1'b0);
    check("s4_align_err", align_err_o, 1);
    check("s4_no_write", count_o, 0);
    check("s4_no_ovf", ovf_o, 0);
    tick(4'h0, '0, 1'b1, 1'b1);
    check("s4_align_clr", align_err_o, 0);
    tick(4'b1011, row(41), 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b1);
    check("s4_event_wins", align_err_o, 1);
    tick(4'h0, '0, 1'b1, 1'b1);
    check("s4_align_clr2", align_err_o, 0);

    // Reset with three rows buffered and one in flight
    for (int k = 50; k <= 53; k++) tick(4'hF, row(k), 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    tick(4'h0, '0, 1'b0, 1'b0);
    check("s5_three", count_o, 3);
    clear_hist();
    rst_ni = 1'b0;
    #1;
    check("s5_rst_count", count_o, 0);
    check("s5_rst_valid", row_valid_o, 0);
    check("s5_rst_row", row_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) tick(4'h0, '0, 1'b1, 1'b0);
    check("s5_no_stale_count", count_o, 0);
    check("s5_no_stale_valid", row_valid_o, 0);
    check("s5_no_align", align_err_o, 0);
    tick(4'hF, row(60), 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s5_post_not_yet", row_valid_o, 0);
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s5_post_valid", row_valid_o, 1);
    check("s5_post_row", row_o, row(60));
    tick(4'h0, '0, 1'b1, 1'b0);
    check("s5_post_empty", count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/syst_deskew.md
SYST_DESKEW -- requirements
Module: syst_deskew

Interface
REQ-001 Parameter N_COLS, default 4, number of array columns drained (>=2).
REQ-002 Parameter SO_WIDTH, default 17, width of one column partial sum.
REQ-003 Parameter DEPTH, default 4, aligned-row buffer depth in rows (power of 2).
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 valid_i  in  N_COLS  per-column valid from bottom-row nodes; bit c = column c.
REQ-007 psumm_i  in  N_COLS*SO_WIDTH  per-column partial sums; column c at bits [c*SO_WIDTH +: SO_WIDTH].
REQ-008 row_o  out  N_COLS*SO_WIDTH  aligned result row, same packing as psumm_i.
REQ-009 row_valid_o  out  1  row_o holds a buffered row.
REQ-010 row_ready_i  in  1  consumer accepts row_o when high with row_valid_o.
REQ-011 count_o  out  $clog2(DEPTH)+1  rows currently buffered.
REQ-012 ovf_o  out  1  sticky: a row was dropped because the buffer was full.
REQ-013 align_err_o  out  1  sticky: a skew-misaligned row was detected.
REQ-014 err_clr_i  in  1  synchronous clear of ovf_o and align_err_o.

Function
REQ-015 Input timing contract: a row sampled at edge T on column 0 arrives on column c at edge T+c.
REQ-016 Column c SHALL pass through N_COLS-1-c delay registers (value and valid); column N_COLS-1 has none.
REQ-017 Delay registers SHALL shift every cycle regardless of valid_i.
REQ-018 Aligned vector = delayed columns 0..N_COLS-2 plus live column N_COLS-1; all-valid = AND of aligned valids.
REQ-019 On an edge where all-valid is high, the aligned row SHALL be written to the buffer (edge T+N_COLS-1).
REQ-020 If aligned valids are neither all high nor all low, no write SHALL occur and align_err_o SHALL set.
REQ-021 row_valid_o SHALL be (count_o != 0); a row written into an empty buffer appears the cycle after the write edge.
REQ-022 Pop on edge where row_valid_o && row_ready_i; row_o SHALL be stable while row_valid_o && !row_ready_i.
REQ-023 Rows SHALL leave in arrival order; pointers wrap modulo DEPTH.
REQ-024 Write when full with simultaneous pop SHALL succeed; count_o unchanged.
REQ-025 Write when full without pop SHALL drop the incoming row, set ovf_o, leave contents unchanged.
REQ-026 Simultaneous write and pop when count_o==1 SHALL keep row_valid_o high with the new row next.
REQ-027 err_clr_i SHALL clear both flags; a same-cycle new error event wins (flag stays set).
REQ-028 Values SHALL pass through bit-exact; no arithmetic performed.

Reset
REQ-029 On rst_ni low: delay registers, pointers, count_o, ovf_o, align_err_o SHALL be 0; row_valid_o 0; row_o 0.
REQ-030 Reset mid-operation SHALL discard in-flight and buffered rows; first post-reset row obeys REQ-019 timing.

Structure
REQ-031 Package syst_pkg SHALL hold default N_COLS, SO_WIDTH, DEPTH constants and a psum_t typedef.
REQ-032 Buffer SHALL be one sub-module syst_row_fifo (width N_COLS*SO_WIDTH, DEPTH, count output).
REQ-033 Delay lines SHALL be generated per column inside syst_deskew.

Verification
REQ-034 N_COLS=4: row {1,2,3,4} skewed at edges 0..3, ready high -> row_valid_o cycle 4, row_o={1,2,3,4}, count_o back to 0.
REQ-035 Ready low, 5 skewed rows 10..14 back-to-back -> count_o=4, ovf_o=1, drain yields 10,11,12,13 in order.
REQ-036 Full buffer, new row written same edge as pop -> count_o stays 4, no ovf_o, new row is last out.
REQ-037 Column 2 valid missing for one row -> no write, align_err_o=1; err_clr_i pulse -> flag 0.
REQ-038 rst_ni low for 1 cycle with 3 rows buffered and 1 in flight -> count_o=0, row_valid_o=0, no stale row emerges.
